// File: rtl/spi_neopix_frame_scheduler.sv
// -----------------------------------------------------------------------------
// spi_neopix_frame_scheduler
//
// Round-robin scheduler that lets exactly one NeoPixel strip controller drive
// its bitstream at a time. A requesting strip is granted, must raise its busy
// flag within START_TIMEOUT cycles, may stay busy for at most FRAME_TIMEOUT
// cycles, and is always followed by a GAP_CYCLES idle gap (the latch/reset
// time of the LED chain) before the next strip is considered.
//
// Ports
//   clk_i         system clock, all logic on the rising edge
//   reset_i       synchronous, active-high reset
//   req_i         per-strip "frame ready" level
//   bsy_i         per-strip "bitstream active" level
//   grant_o       one-hot permission to start output (registered)
//   active_idx_o  index of the current / last granted strip (registered)
//   busy_o        high whenever the scheduler is not IDLE (registered)
//   timeout_o     one-cycle pulse on a start or frame timeout (registered)
// -----------------------------------------------------------------------------
module spi_neopix_frame_scheduler #(
  parameter int NUM_STRIPS    = 2,
  parameter int SYSTEM_CLOCK  = 50000000,
  parameter int GAP_CYCLES    = SYSTEM_CLOCK / 12500,
  parameter int START_TIMEOUT = 1000,
  parameter int FRAME_TIMEOUT = SYSTEM_CLOCK / 50,
  localparam int IDX_W        = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_STRIPS-1:0] req_i,
  input  logic [NUM_STRIPS-1:0] bsy_i,
  output logic [NUM_STRIPS-1:0] grant_o,
  output logic [IDX_W-1:0]      active_idx_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  // Shared dwell counter is sized for the longest interval it must measure.
  localparam int CNT_MAX_A = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > FRAME_TIMEOUT) ? CNT_MAX_A : FRAME_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [IDX_W-1:0]      rr_q,      rr_d;
  logic [NUM_STRIPS-1:0] grant_q,   grant_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic                  busy_q,    busy_d;
  logic                  timeout_q, timeout_d;

  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      winner_next;
  logic [IDX_W-1:0]      cand_idx;
  logic                  found;
  int                    cand;

  // Round-robin pick: first requesting index at or above rr_q, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_STRIPS; k++) begin
      cand     = (int'(rr_q) + k) % NUM_STRIPS;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
    winner_next = (int'(winner) == NUM_STRIPS - 1) ? '0 : winner + IDX_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          grant_d = NUM_STRIPS'(1) << winner;
          idx_d   = winner;
          rr_d    = winner_next;
        end
      end
      S_GRANT: begin
        // A busy rise wins over a simultaneous timeout expiry.
        if (bsy_i[idx_q]) begin
          state_d = S_ACTIVE;
          grant_d = '0;
        end else if (cnt_q == START_LAST) begin
          state_d   = S_GAP;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACTIVE: begin
        if (!bsy_i[idx_q]) begin
          state_d = S_GAP;
        end else if (cnt_q == FRAME_LAST) begin
          state_d   = S_GAP;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    // Counter measures dwell in the current state only; increments above
    // stop at each threshold, so it never wraps.
    if (state_d != state_q) cnt_d = '0;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o      = grant_q;
  assign active_idx_o = idx_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_spi_neopix_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_neopix_frame_scheduler
//
// Drives whole strip services (request, start delay, frame length, gap) with
// randomized glitches on the ignored inputs, and predicts grants from a
// round-robin pointer model and timings from the configured interval lengths.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_neopix_frame_scheduler;

  localparam int NS    = 2;
  localparam int GAP   = 4;
  localparam int START = 8;
  localparam int FRAME = 20;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [NS-1:0] req_i;
  logic [NS-1:0] bsy_i;
  logic [NS-1:0] grant_o;
  logic [0:0]    active_idx_o;
  logic          busy_o;
  logic          timeout_o;

  int errors   = 0;
  int checks   = 0;
  int to_cnt   = 0;
  int rr_model = 0;

  spi_neopix_frame_scheduler #(
    .NUM_STRIPS   (NS),
    .SYSTEM_CLOCK (50000000),
    .GAP_CYCLES   (GAP),
    .START_TIMEOUT(START),
    .FRAME_TIMEOUT(FRAME)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .bsy_i       (bsy_i),
    .grant_o     (grant_o),
    .active_idx_o(active_idx_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  // Count every timeout pulse seen, sampled mid-cycle.
  always @(negedge clk) if (timeout_o === 1'b1) to_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first requester at or above the pointer, wrapping.
  function automatic int model_pick(input logic [NS-1:0] r, input int ptr);
    for (int k = 0; k < NS; k++) begin
      if (r[(ptr + k) % NS]) return (ptr + k) % NS;
    end
    return -1;
  endfunction

  // Random bsy pattern with the serviced strip's bit forced.
  function automatic logic [NS-1:0] glitch(input int w, input logic v);
    logic [NS-1:0] b;
    b    = NS'($urandom);
    b[w] = v;
    return b;
  endfunction

  task automatic apply_reset();
    reset_i = 1'b1;
    req_i   = '0;
    bsy_i   = '0;
    tick();
    reset_i  = 1'b0;
    rr_model = 0;
  endtask

  // One complete service from IDLE back to IDLE. d = GRANT cycles with busy
  // low before it rises; l = ACTIVE cycles with busy high before it falls.
  task automatic do_service(input logic [NS-1:0] req, input int d, input int l, output int w);
    int            to0;
    logic [NS-1:0] wm;
    bit            exp_to;
    bit            stuck;
    w = model_pick(req, rr_model);
    rr_model = (w + 1) % NS;
    wm = '0;
    wm[w] = 1'b1;
    exp_to = (d >= START) || (l >= FRAME);
    stuck  = (d < START) && (l >= FRAME);
    to0    = to_cnt;

    req_i = req;
    bsy_i = '0;
    tick();
    checks++; if (grant_o !== wm) begin errors++; $display("FAIL grant_on_req: got %b want %b", grant_o, wm); end
    checks++; if (active_idx_o !== 1'(w)) begin errors++; $display("FAIL idx_on_req: got %0d want %0d", active_idx_o, w); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_on_req: got %b want 1", busy_o); end

    if (d >= START) begin
      for (int i = 1; i <= START; i++) begin
        req_i = NS'($urandom);
        bsy_i = glitch(w, 1'b0);
        tick();
        if (i < START) begin
          checks++; if (grant_o !== wm) begin errors++; $display("FAIL grant_hold_%0d: got %b want %b", i, grant_o, wm); end
        end
      end
      checks++; if (grant_o !== '0) begin errors++; $display("FAIL grant_clr_start_to: got %b want 00", grant_o); end
      checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL start_timeout_pulse: got %b want 1", timeout_o); end
    end else begin
      for (int i = 1; i <= d; i++) begin
        req_i = NS'($urandom);
        bsy_i = glitch(w, 1'b0);
        tick();
        checks++; if (grant_o !== wm) begin errors++; $display("FAIL grant_wait_%0d: got %b want %b", i, grant_o, wm); end
      end
      req_i = NS'($urandom);
      bsy_i = glitch(w, 1'b1);
      tick();
      checks++; if (grant_o !== '0) begin errors++; $display("FAIL grant_clr_on_bsy: got %b want 00", grant_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_active: got %b want 1", busy_o); end
      if (l >= FRAME) begin
        for (int i = 1; i <= FRAME; i++) begin
          bsy_i = glitch(w, 1'b1);
          tick();
          if (i < FRAME) begin
            checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL early_frame_to_%0d: got %b want 0", i, timeout_o); end
          end
        end
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL frame_timeout_pulse: got %b want 1", timeout_o); end
      end else begin
        for (int i = 1; i <= l; i++) begin
          req_i = NS'($urandom);
          bsy_i = glitch(w, 1'b1);
          tick();
          checks++; if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin errors++; $display("FAIL active_%0d: busy=%b to=%b want 1/0", i, busy_o, timeout_o); end
        end
        bsy_i = glitch(w, 1'b0);
        tick();
        checks++; if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin errors++; $display("FAIL gap_entry: busy=%b to=%b want 1/0", busy_o, timeout_o); end
      end
    end

    for (int i = 1; i <= GAP; i++) begin
      req_i = NS'($urandom);
      bsy_i = stuck ? glitch(w, 1'b1) : NS'($urandom);
      tick();
      if (i < GAP) begin
        checks++; if (busy_o !== 1'b1 || grant_o !== '0 || timeout_o !== 1'b0) begin
          errors++; $display("FAIL gap_%0d: busy=%b grant=%b to=%b want 1/00/0", i, busy_o, grant_o, timeout_o);
        end
      end else begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL gap_end_idle: busy=%b want 0", busy_o); end
      end
    end
    checks++; if (active_idx_o !== 1'(w)) begin errors++; $display("FAIL idx_kept: got %0d want %0d", active_idx_o, w); end
    req_i = '0;
    bsy_i = '0;
    checks++; if ((to_cnt - to0) != int'(exp_to)) begin errors++; $display("FAIL timeout_count: got %0d want %0d", to_cnt - to0, exp_to); end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    req_i   = '1;
    bsy_i   = '1;
    tick();
    checks++; if (grant_o !== '0) begin errors++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    checks++; if (active_idx_o !== 1'b0) begin errors++; $display("FAIL reset_idx: got %0d want 0", active_idx_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    apply_reset();
  endtask

  task automatic test_single();
    int w;
    apply_reset();
    do_service(2'b01, 2, 9, w);
    tick();
    checks++; if (busy_o !== 1'b0 || grant_o !== '0) begin errors++; $display("FAIL single_stays_idle: busy=%b grant=%b", busy_o, grant_o); end
  endtask

  task automatic test_back_to_back();
    int w;
    int want [4] = '{0, 1, 0, 1};
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      do_service(2'b11, int'($urandom_range(0, START - 1)), int'($urandom_range(0, FRAME - 1)), w);
      checks++; if (w != want[s]) begin errors++; $display("FAIL rr_order_%0d: model %0d want %0d", s, w, want[s]); end
    end
  endtask

  task automatic test_start_timeout();
    int w;
    apply_reset();
    do_service(2'b10, START, 0, w);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busy_o !== 1'b0 || grant_o !== '0) begin errors++; $display("FAIL no_req_idle_%0d: busy=%b grant=%b", i, busy_o, grant_o); end
    end
    do_service(2'b11, 1, 3, w);
  endtask

  task automatic test_frame_timeout();
    int w;
    apply_reset();
    do_service(2'b01, 1, FRAME + 5, w);
  endtask

  task automatic test_reset_active();
    int to0;
    apply_reset();
    to0   = to_cnt;
    req_i = 2'b11;
    tick();
    bsy_i = 2'b01;
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    bsy_i   = '0;
    checks++; if (grant_o !== '0 || active_idx_o !== 1'b0 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_active: grant=%b idx=%0d busy=%b to=%b want all 0", grant_o, active_idx_o, busy_o, timeout_o);
    end
    tick();
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL grant_after_reset: got %b want 01", grant_o); end
    checks++; if (to_cnt != to0) begin errors++; $display("FAIL reset_no_timeout: got %0d pulses want 0", to_cnt - to0); end
    apply_reset();
  endtask

  task automatic test_random();
    int w;
    apply_reset();
    for (int s = 0; s < 12; s++) begin
      do_service(NS'($urandom_range(1, 3)), int'($urandom_range(0, START + 2)),
                 int'($urandom_range(0, FRAME + 3)), w);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    req_i   = '0;
    bsy_i   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_start_timeout();
    test_frame_timeout();
    test_reset_active();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_neopix_frame_scheduler.md
SPI_NEOPIX_FRAME_SCHEDULER -- requirements
Module: spi_neopix_frame_scheduler

Interface
REQ-001 Parameters SHALL be name, default, meaning, one per line:
- NUM_STRIPS, 2, number of strip controllers sharing the output power/timing budget.
- SYSTEM_CLOCK, 50000000, clk_i frequency in Hz.
- GAP_CYCLES, SYSTEM_CLOCK/12500, mandatory idle gap (80 us) after each strip transfer.
- START_TIMEOUT, 1000, max cycles from grant to bsy_i rise.
- FRAME_TIMEOUT, SYSTEM_CLOCK/50, max cycles bsy_i may stay high (20 ms).
REQ-002 Ports SHALL be name, direction, width, meaning, one per line:
- clk_i, in, 1, single system clock; all logic on its rising edge.
- reset_i, in, 1, synchronous, active-high reset.
- req_i, in, NUM_STRIPS, level; strip n has a frame ready to send.
- bsy_i, in, NUM_STRIPS, level; strip n bitstream output active (ws_bsy).
- grant_o, out, NUM_STRIPS, one-hot level; permission for strip n to start output.
- active_idx_o, out, clog2(NUM_STRIPS) (min 1), index of current/last granted strip.
- busy_o, out, 1, high whenever state is not IDLE.
- timeout_o, out, 1, one-cycle pulse on start or frame timeout.
REQ-003 All outputs SHALL be registered; no combinational input-to-output paths.

Function
REQ-004 FSM states SHALL be IDLE, GRANT, ACTIVE, GAP; exactly one strip is serviced at a time.
REQ-005 IDLE: if any req_i bit high, next cycle SHALL enter GRANT with grant_o one-hot at the winner and active_idx_o = winner.
REQ-006 Winner SHALL be the first requesting index at or above rr_ptr, wrapping modulo NUM_STRIPS; rr_ptr SHALL load (winner+1) mod NUM_STRIPS on entering GRANT.
REQ-007 GRANT: on a cycle where bsy_i[active] is high, next state SHALL be ACTIVE and grant_o SHALL return to 0 on that same transition.
REQ-008 GRANT: if bsy_i[active] has not risen after START_TIMEOUT cycles in GRANT, SHALL clear grant_o, pulse timeout_o one cycle, enter GAP.
REQ-009 ACTIVE: on a cycle where bsy_i[active] is low, next state SHALL be GAP.
REQ-010 ACTIVE: after FRAME_TIMEOUT cycles with bsy_i[active] high, SHALL pulse timeout_o one cycle and enter GAP.
REQ-011 GAP SHALL last exactly GAP_CYCLES cycles, then enter IDLE; req_i SHALL be ignored during GAP.
REQ-012 One shared cycle counter SHALL clear on every state change; width sized for max(GAP_CYCLES, START_TIMEOUT, FRAME_TIMEOUT); it SHALL never wrap.
REQ-013 req_i/bsy_i on non-granted indices SHALL be ignored outside IDLE; withdrawal of req_i[active] after grant SHALL NOT abort the sequence.
REQ-014 Simultaneous requests SHALL be resolved solely by REQ-006; a strip whose req_i stays high SHALL wait at most NUM_STRIPS-1 other services.
REQ-015 busy_o SHALL be high in GRANT, ACTIVE, GAP; low in IDLE.
REQ-016 Minimum IDLE-to-IDLE turnaround SHALL be 1 + GRANT dwell + ACTIVE dwell + GAP_CYCLES cycles; back-to-back requests SHALL return to IDLE for one cycle between services.

Reset
REQ-017 reset_i high at a clock edge SHALL force: state IDLE, grant_o 0, active_idx_o 0, busy_o 0, timeout_o 0, rr_ptr 0, counter 0.
REQ-018 Reset mid-sequence (any state) SHALL abort immediately with no timeout_o pulse; first grant after release SHALL favour index 0.
REQ-019 No state SHALL depend on initial register values without reset_i.

Verification (NUM_STRIPS=2, GAP_CYCLES=4, START_TIMEOUT=8, FRAME_TIMEOUT=20)
REQ-020 Single request: req_i=01, bsy_i[0] high 3 cycles after grant for 10 cycles -> grant_o=01 one cycle after req, clears when bsy seen, busy_o drops exactly 4 cycles after bsy_i[0] falls.
REQ-021 Simultaneous: req_i=11 held, strips respond normally -> grant order 0,1,0,1; active_idx_o alternates; one IDLE cycle between services.
REQ-022 Start timeout: req_i=10, bsy_i held 0 -> grant_o=10 for 8 cycles, timeout_o one pulse, 4 GAP cycles, next grant to 0 only if req_i[0].
REQ-023 Frame timeout: bsy_i[0] stuck high -> timeout_o pulse 20 cycles after entering ACTIVE, GAP, then IDLE; no second pulse.
REQ-024 Reset in ACTIVE: reset_i one cycle -> all outputs 0 next cycle, no timeout_o; with req_i=11 next grant is 01.
REQ-025 Glitch immunity: bsy_i[1] toggles while strip 0 is ACTIVE, req_i[1] pulses during GAP -> no effect on state or grant_o.
